// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: one request in flight, one-cycle memory access, registered response.
// Accept to rsp_valid takes 2 edges (1 when misaligned); req_ready stays low until the granted port takes its response.
module dmem_arbiter #(
   parameter int REG_WIDTH = 64,
   parameter int PRIO_MODE = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0]             req_we,
   input  logic [1:0]             req_sign,
   input  logic [3:0]             req_width,
   input  logic [2*REG_WIDTH-1:0] req_addr,
   input  logic [2*REG_WIDTH-1:0] req_wdata,
   output logic [1:0]             rsp_valid,
   input  logic [1:0]             rsp_ready,
   output logic [REG_WIDTH-1:0]   rsp_rdata,
   output logic                   rsp_err,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   MemSign,
   output logic [1:0]             MemWidth,
   output logic [REG_WIDTH-1:0]   wdata,
   output logic [REG_WIDTH-1:0]   full_addr,
   input  logic [REG_WIDTH-1:0]   rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef struct packed {
      logic                 we;
      logic                 sign;
      logic [1:0]           width;
      logic [REG_WIDTH-1:0] addr;
      logic [REG_WIDTH-1:0] wdata;
   } req_t;

   state_e               state_q, state_d;
   req_t                 req_q, req_d, win_req;
   logic                 last_grant_q, last_grant_d;
   logic                 gnt_port_q, gnt_port_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [REG_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                 win_vld, win_port, win_misaligned;
   logic                 accept, rsp_ack;

   // A tie goes to the port that was not served last, unless fixed priority is selected.
   always_comb begin
      win_vld  = |req_valid;
      win_port = 1'b0;
      case (req_valid)
         2'b10:   win_port = 1'b1;
         2'b11:   win_port = (PRIO_MODE == 1) ? 1'b0 : ~last_grant_q;
         default: win_port = 1'b0;
      endcase
   end

   always_comb begin
      win_req.we    = req_we[win_port];
      win_req.sign  = req_sign[win_port];
      win_req.width = win_port ? req_width[3:2] : req_width[1:0];
      win_req.addr  = win_port ? req_addr[2*REG_WIDTH-1:REG_WIDTH] : req_addr[REG_WIDTH-1:0];
      win_req.wdata = win_port ? req_wdata[2*REG_WIDTH-1:REG_WIDTH] : req_wdata[REG_WIDTH-1:0];
   end

   always_comb begin
      case (win_req.width)
         2'd1:    win_misaligned = win_req.addr[0];
         2'd2:    win_misaligned = |win_req.addr[1:0];
         2'd3:    win_misaligned = |win_req.addr[2:0];
         default: win_misaligned = 1'b0;
      endcase
   end

   // Gated by rst_n so ready is low throughout reset, not just after the first edge.
   assign req_ready = (state_q == IDLE && rst_n && win_vld) ? (win_port ? 2'b10 : 2'b01) : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign rsp_ack   = (state_q == RESP) && rsp_ready[gnt_port_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         req_q        <= '0;
         last_grant_q <= 1'b1;
         gnt_port_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         last_grant_q <= last_grant_d;
         gnt_port_q   <= gnt_port_d;
         rsp_err_q    <= rsp_err_d;
         rsp_rdata_q  <= rsp_rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = win_misaligned ? RESP : ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    if (rsp_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Misaligned requests are still latched; the memory strobes stay low because ACCESS is skipped.
   always_comb begin
      req_d        = req_q;
      last_grant_d = last_grant_q;
      gnt_port_d   = gnt_port_q;
      rsp_err_d    = rsp_err_q;
      rsp_rdata_d  = rsp_rdata_q;
      if (accept) begin
         req_d        = win_req;
         last_grant_d = win_port;
         gnt_port_d   = win_port;
         rsp_err_d    = win_misaligned;
         rsp_rdata_d  = '0;
      end
      if (state_q == ACCESS) begin
         rsp_rdata_d = req_q.we ? '0 : rdata;
      end
      if (rsp_ack) begin
         rsp_err_d   = 1'b0;
         rsp_rdata_d = '0;
      end
   end

   always_comb begin
      rsp_valid = 2'b00;
      if (state_q == RESP) begin
         rsp_valid[gnt_port_q] = 1'b1;
      end
      rsp_rdata = rsp_rdata_q;
      rsp_err   = rsp_err_q;
      MemRead   = (state_q == ACCESS) && !req_q.we;
      MemWrite  = (state_q == ACCESS) && req_q.we;
      MemSign   = req_q.sign;
      MemWidth  = req_q.width;
      wdata     = req_q.wdata;
      full_addr = req_q.addr;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between two requesters: port 0 (core load/store path) and port 1 (DMA/debug loader).
- Accepts one request at a time over valid/ready and drives the memory control/address/data for exactly one cycle.
- Captures the asynchronous read data and returns it through a registered, per-port response handshake.
- Rejects misaligned accesses with an error response and never touches memory for them.

Parameters:
- REG_WIDTH, 64, data/address width of requests and memory.
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (port 0 wins).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-port request valid (bit i = port i).
- req_ready  out  2  per-port request ready.
- req_we  in  2  per-port access type: 1 = store, 0 = load.
- req_sign  in  2  per-port MemSign value: 0 = sign-extend, 1 = zero-extend.
- req_width  in  4  per-port MemWidth, port i at bits [2i+1:2i]: 0 = byte, 1 = half, 2 = word, 3 = dword.
- req_addr  in  2*REG_WIDTH  per-port byte address, port i at bits [(i+1)*REG_WIDTH-1 : i*REG_WIDTH].
- req_wdata  in  2*REG_WIDTH  per-port store data, same packing as req_addr.
- rsp_valid  out  2  per-port response valid, one-hot or zero.
- rsp_ready  in  2  per-port response ready.
- rsp_rdata  out  REG_WIDTH  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned-access flag, qualified by rsp_valid.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- MemSign  out  1  memory sign select.
- MemWidth  out  2  memory access width.
- wdata  out  REG_WIDTH  memory write data.
- full_addr  out  REG_WIDTH  memory byte address.
- rdata  in  REG_WIDTH  memory read data, combinational from full_addr.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset value is IDLE.
- Reset values: last_grant=1 (so port 0 wins the first round-robin tie); all outputs 0, including rsp_*, MemRead, MemWrite and req_ready.
- IDLE arbitration: winner is computed combinationally from req_valid.
  - Only one port requesting: that port wins.
  - Both requesting, PRIO_MODE=0: the port != last_grant wins.
  - Both requesting, PRIO_MODE=1: port 0 wins.
  - req_ready is asserted only for the winner and only in IDLE.
- Acceptance: on valid&&ready the block latches we/sign/width/addr/wdata, records the granted port, and updates last_grant.
  - Misaligned means addr[0]!=0 for half, addr[1:0]!=0 for word, or addr[2:0]!=0 for dword. Byte accesses are never misaligned.
  - Misaligned: set err and go straight to RESP.
  - Otherwise: go to ACCESS.
- ACCESS lasts exactly 1 cycle.
  - MemRead=~we, MemWrite=we; MemSign, MemWidth, full_addr and wdata come from the latched fields.
  - The store commits in memory at the closing edge.
  - At that edge a load captures rdata into rsp_rdata; a store sets rsp_rdata=0.
  - Next state is RESP.
- Outside ACCESS: MemRead=MemWrite=0, and the address/data/control outputs hold their latched values.
- RESP: rsp_valid[granted]=1 with rsp_rdata and rsp_err held stable until rsp_ready[granted].
  - On rsp_ready[granted], go to IDLE and clear rsp_valid, rsp_err and rsp_rdata.
  - rsp_ready of the other port is ignored.
- Latency and throughput:
  - Accept edge T0; ACCESS during cycle T0..T1; rsp_valid high from T1.
  - With rsp_ready tied high, the response completes at T2, giving a minimum 3-cycle spacing between accepted requests.
  - Misaligned requests complete in 2 cycles.
- Requester drops req_valid before acceptance: nothing is latched, and the arbitration is re-evaluated on the next cycle.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and MemWrite drops asynchronously, so a store in ACCESS does not commit if rst_n falls before the edge. Any pending response is discarded.
- Invariants:
  - MemRead and MemWrite are never both 1.
  - At most one bit of req_ready is set.
  - At most one bit of rsp_valid is set.

Test Plan:
- Single store then load, port 0:
  - Stimulus: store width=3, addr=0x10, wdata=0x1122334455667788; then load width=3, addr=0x10.
  - Required: the load responds rsp_rdata=0x1122334455667788 with rsp_err=0; MemWrite is high for exactly 1 cycle.
- Sign handling, port 1:
  - Stimulus: store byte 0x80 at 0x20; then load byte with sign=0, then with sign=1.
  - Required: rsp_rdata=0xFFFFFFFFFFFFFF80, then 0x0000000000000080.
- Round-robin, PRIO_MODE=0:
  - Stimulus: both ports hold req_valid continuously from reset, rsp_ready tied high.
  - Required: grants go 0,1,0,1; each accept is 3 cycles apart.
  - Same stimulus with PRIO_MODE=1: port 0 is granted every time.
- Misaligned access:
  - Stimulus: word store at addr=0x22.
  - Required: rsp_err=1, rsp_rdata=0, MemWrite never asserts, and memory at 0x20..0x27 is unchanged (checked by a later dword load).
- Response backpressure:
  - Stimulus: load on port 0 with rsp_ready held 0 for 5 cycles while port 1 requests.
  - Required: rsp_valid[0] and rsp_rdata stay stable; req_ready[1] stays 0; port 1 is granted the cycle after rsp_ready[0] rises.
- Reset mid-store:
  - Stimulus: drive rst_n low during the ACCESS cycle of a store of 0xAA to 0x30.
  - Required: all outputs go to 0 immediately, and a later byte load of 0x30 returns the prior value (not 0xAA).
